// File: rtl/uart_byte_rx_if.sv
// -----------------------------------------------------------------------------
// uart_byte_rx_if
// Receive-side user bus of the UART byte receiver.
//   o_user_rx_data   received word, LSB = first data bit on the line
//   o_user_rx_valid  one-cycle strobe, o_user_rx_data valid in that cycle
//   o_rx_frame_err   one-cycle strobe on a bad stop bit
//   o_rx_parity_err  one-cycle strobe on a parity mismatch
//   o_rx_busy        high while a frame is being received
// Handshake: o_user_rx_valid is a pure strobe with no ready/backpressure.
// The consumer must take o_user_rx_data in the cycle o_user_rx_valid is
// high; the word then holds until the next good frame replaces it.
// Modports: master = receiver (drives), slave = user logic (observes).
// -----------------------------------------------------------------------------
interface uart_byte_rx_if #(
  parameter int P_UART_DATA_WIDTH = 8
);
  logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data;
  logic                         o_user_rx_valid;
  logic                         o_rx_frame_err;
  logic                         o_rx_parity_err;
  logic                         o_rx_busy;

  modport master (
    output o_user_rx_data,
    output o_user_rx_valid,
    output o_rx_frame_err,
    output o_rx_parity_err,
    output o_rx_busy
  );

  modport slave (
    input o_user_rx_data,
    input o_user_rx_valid,
    input o_rx_frame_err,
    input o_rx_parity_err,
    input o_rx_busy
  );
endinterface

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// Standalone UART receiver running on the system clock. It samples the line
// in the middle of each bit, rejects short start-bit glitches, and flags bad
// stop bits (and parity mismatches when parity is compiled in).
// Optional feature macro: UART_PARITY_EN (adds a parity bit after the data).
// Ports:
//   i_clk        system clock
//   i_rst        synchronous, active-high reset
//   i_uart_rx    asynchronous serial line, idle high
//   rx_if        user bus (master modport), see uart_byte_rx_if
//   o_dbg_state  current FSM state, for observation only
// -----------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int P_SYSTEM_CLK      = 50_000_000,
  parameter int P_UART_BUADRATE   = 9600,
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_uart_rx,
  uart_byte_rx_if.master        rx_if,
  output logic [2:0]            o_dbg_state
);

  localparam int P_BIT_CNT  = P_SYSTEM_CLK / P_UART_BUADRATE;
  localparam int P_HALF_CNT = P_BIT_CNT / 2;
  localparam int CNT_W      = $clog2(P_BIT_CNT);
  localparam int BITS_W     = $clog2(P_UART_DATA_WIDTH + 1);
  localparam int W          = P_UART_DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BITS_W-1:0]  bits_q, bits_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [W-1:0]       data_q, data_d;
  logic               ferr_acc_q, ferr_acc_d;
  logic               valid_q, valid_d;
  logic               ferr_q, ferr_d;
  logic               perr_q, perr_d;
  logic               busy_q, busy_d;
  logic               sync1_q, sync2_q, prev_q;
  logic               bit_tick, half_tick, frame_bad, parity_bad;

`ifdef UART_PARITY_EN
  logic               parity_bit_q, parity_bit_d;
  // Expected parity: XOR of data bits, inverted for odd sense.
  assign parity_bad = parity_bit_q != ((^shreg_q) ^ (P_UART_CHECK != 0));
`else
  assign parity_bad = 1'b0;
`endif

  assign bit_tick  = (cnt_q == CNT_W'(P_BIT_CNT - 1));
  assign half_tick = (cnt_q == CNT_W'(P_HALF_CNT - 1));
  // A frame is bad if any earlier stop sample or the current one was low.
  assign frame_bad = ferr_acc_q | ~sync2_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bits_d     = bits_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    ferr_acc_d = ferr_acc_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
`ifdef UART_PARITY_EN
    parity_bit_d = parity_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        bits_d     = '0;
        ferr_acc_d = 1'b0;
        if (prev_q && !sync2_q) state_d = S_START;
      end
      S_START: begin
        if (half_tick) begin
          cnt_d   = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = sync2_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[W-1:1]};
          if (bits_q == BITS_W'(W - 1)) begin
            bits_d = '0;
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bits_d = bits_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          cnt_d        = '0;
          parity_bit_d = sync2_q;
          state_d      = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (bits_q == BITS_W'(P_UART_STOP_WIDTH - 1)) begin
            state_d = S_IDLE;
            ferr_d  = frame_bad;
            perr_d  = parity_bad;
            valid_d = !frame_bad && !parity_bad;
            if (!frame_bad && !parity_bad) data_d = shreg_q;
          end else begin
            bits_d     = bits_q + 1'b1;
            ferr_acc_d = frame_bad;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered so busy falls in the same cycle the end-of-frame strobe rises.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      shreg_q    <= '0;
      data_q     <= '0;
      ferr_acc_q <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_PARITY_EN
      parity_bit_q <= 1'b0;
`endif
    end else begin
      sync1_q    <= i_uart_rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bits_q     <= bits_d;
      shreg_q    <= shreg_d;
      data_q     <= data_d;
      ferr_acc_q <= ferr_acc_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      busy_q     <= busy_d;
`ifdef UART_PARITY_EN
      parity_bit_q <= parity_bit_d;
`endif
    end
  end

  assign rx_if.o_user_rx_data  = data_q;
  assign rx_if.o_user_rx_valid = valid_q;
  assign rx_if.o_rx_frame_err  = ferr_q;
  assign rx_if.o_rx_parity_err = perr_q;
  assign rx_if.o_rx_busy       = busy_q;
  assign o_dbg_state           = state_q;

endmodule
